// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Build option: ALU_STATUS_BYTE_EN adds a leading status byte to every response.
package alu_pkg;

    localparam int unsigned IO_W = 28;
    localparam logic [IO_W-1:0] IO_OEB = 28'h00003FF;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_A,
        ST_GET_B,
        ST_EXEC,
        ST_DIV_WAIT,
        ST_RESP,
`ifdef ALU_STATUS_BYTE_EN
        ST_SEND_STS,
`endif
        ST_SEND_LO,
        ST_SEND_HI
    } state_e;

    localparam int unsigned STS_OP_LSB = 0;
    localparam int unsigned STS_ZERO   = 2;
    localparam int unsigned STS_CB     = 3;
    localparam int unsigned STS_DZ     = 4;

    // Status byte: {3'b0, div0_this_op, carry_or_borrow, result_zero, opcode}
    function automatic logic [7:0] status_byte(input alu_op_e op, input logic dz,
                                               input logic cb, input logic zero);
        logic [7:0] s;
        s                     = '0;
        s[STS_OP_LSB +: 2]    = op;
        s[STS_ZERO]           = zero;
        s[STS_CB]             = cb;
        s[STS_DZ]             = dz;
        return s;
    endfunction

endpackage

// File: rtl/alu_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit is
// produced on the start edge so done pulses N-1 cycles after start.
module alu_seq_divider #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] q,
    output logic [W-1:0] r
);

    localparam int unsigned CNT_W = $clog2(N + 1);

    logic [W-1:0]     rem, quo, dvs;
    logic [W-1:0]     src_rem, src_quo, src_dvs;
    logic [W-1:0]     nxt_rem, nxt_quo;
    logic [W:0]       sh;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic             accept;

    assign accept = start & ~running;
    assign q      = quo;
    assign r      = rem;

    // One restoring step, seeded from the operands on the start edge
    always_comb begin
        src_rem = accept ? '0 : rem;
        src_quo = accept ? a  : quo;
        src_dvs = accept ? b  : dvs;
        sh      = {src_rem, src_quo[W-1]};
        if (sh >= {1'b0, src_dvs}) begin
            nxt_rem = W'(sh - {1'b0, src_dvs});
            nxt_quo = {src_quo[W-2:0], 1'b1};
        end else begin
            nxt_rem = sh[W-1:0];
            nxt_quo = {src_quo[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                rem     <= nxt_rem;
                quo     <= nxt_quo;
                dvs     <= b;
                cnt     <= CNT_W'(N - 1);
                running <= 1'b1;
            end else if (running) begin
                rem <= nxt_rem;
                quo <= nxt_quo;
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Byte-stream front end for the 8-bit ALU: takes (opcode, A, B), returns (lo, hi).
// Build option: ALU_STATUS_BYTE_EN prepends a status byte to the response.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DIV_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              div0,
    output logic [IO_W-1:0]   io_oeb
);

    state_e              state, state_d;
    alu_op_e             opcode, opcode_d;
    logic [DATA_W-1:0]   a, a_d, b, b_d;
    logic [DATA_W-1:0]   res_lo, res_lo_d, res_hi, res_hi_d;
    logic [DATA_W-1:0]   out_data_d;
    logic                in_ready_d, out_valid_d, busy_d, div0_d;
    logic                in_xfer, out_xfer;
    logic                div_start, div_done;
    logic [DATA_W-1:0]   div_q, div_r;
    logic [DATA_W:0]     sum, diff;
    logic [2*DATA_W-1:0] prod;

    assign io_oeb   = IO_OEB;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = {1'b0, a} - {1'b0, b};
    assign prod     = (2*DATA_W)'(a) * (2*DATA_W)'(b);

    alu_seq_divider #(.W(DATA_W), .N(DIV_CYC)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .a     (a),
        .b     (b),
        .done  (div_done),
        .q     (div_q),
        .r     (div_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            opcode    <= ALU_ADD;
            a         <= '0;
            b         <= '0;
            res_lo    <= '0;
            res_hi    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            div0      <= 1'b0;
        end else begin
            state     <= state_d;
            opcode    <= opcode_d;
            a         <= a_d;
            b         <= b_d;
            res_lo    <= res_lo_d;
            res_hi    <= res_hi_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            busy      <= busy_d;
            div0      <= div0_d;
        end
    end

    always_comb begin
        state_d     = state;
        opcode_d    = opcode;
        a_d         = a;
        b_d         = b;
        res_lo_d    = res_lo;
        res_hi_d    = res_hi;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        busy_d      = busy;
        div0_d      = div0;
        div_start   = 1'b0;

        case (state)
            ST_IDLE: if (in_xfer) begin
                opcode_d = alu_op_e'(in_data[1:0]);
                busy_d   = 1'b1;
                state_d  = ST_GET_A;
            end
            ST_GET_A: if (in_xfer) begin
                a_d     = in_data;
                state_d = ST_GET_B;
            end
            ST_GET_B: if (in_xfer) begin
                b_d     = in_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_RESP;
                case (opcode)
                    ALU_ADD: begin
                        res_lo_d = sum[DATA_W-1:0];
                        res_hi_d = DATA_W'(sum[DATA_W]);
                    end
                    ALU_SUB: begin
                        res_lo_d = diff[DATA_W-1:0];
                        res_hi_d = DATA_W'(diff[DATA_W]);
                    end
                    ALU_MUL: {res_hi_d, res_lo_d} = prod;
                    ALU_DIV: begin
                        // Divide by zero never reaches the divider
                        if (b == '0) begin
                            res_lo_d = '1;
                            res_hi_d = a;
                            div0_d   = 1'b1;
                        end else begin
                            div_start = 1'b1;
                            state_d   = ST_DIV_WAIT;
                        end
                    end
                    default: state_d = ST_RESP;
                endcase
            end
            ST_DIV_WAIT: if (div_done) begin
                res_lo_d = div_q;
                res_hi_d = div_r;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                out_valid_d = 1'b1;
`ifdef ALU_STATUS_BYTE_EN
                out_data_d  = DATA_W'(status_byte(opcode,
                                  (opcode == ALU_DIV) && (b == '0),
                                  ((opcode == ALU_ADD) || (opcode == ALU_SUB)) && res_hi[0],
                                  {res_hi, res_lo} == '0));
                state_d     = ST_SEND_STS;
`else
                out_data_d  = res_lo;
                state_d     = ST_SEND_LO;
`endif
            end
`ifdef ALU_STATUS_BYTE_EN
            ST_SEND_STS: if (out_xfer) begin
                out_data_d = res_lo;
                state_d    = ST_SEND_LO;
            end
`endif
            ST_SEND_LO: if (out_xfer) begin
                out_data_d = res_hi;
                state_d    = ST_SEND_HI;
            end
            ST_SEND_HI: if (out_xfer) begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_GET_A) || (state_d == ST_GET_B);
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed plus randomized bench for alu_cmd_sequencer, checked against an
// arithmetic reference model; follows ALU_STATUS_BYTE_EN like the design.
module tb_alu_cmd_sequencer;

    localparam int unsigned DIV_CYC = 8;
`ifdef ALU_STATUS_BYTE_EN
    localparam bit STS_EN = 1'b1;
`else
    localparam bit STS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        div0;
    logic [27:0] io_oeb;

    int   n_checks = 0;
    int   n_fails  = 0;
    logic exp_div0 = 1'b0;

    alu_cmd_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .div0      (div0),
        .io_oeb    (io_oeb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: response bytes and status straight from the arithmetic rules
    function automatic void model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] lo, output logic [7:0] hi,
                                  output logic [7:0] sts);
        int ia, ib, r;
        logic cb, dz;
        ia = int'(a);
        ib = int'(b);
        cb = 1'b0;
        dz = 1'b0;
        case (op)
            2'd0: begin r = ia + ib; lo = 8'(r % 256); hi = 8'(r / 256); cb = (r > 255); end
            2'd1: begin lo = 8'((256 + ia - ib) % 256); hi = (ia < ib) ? 8'd1 : 8'd0; cb = (ia < ib); end
            2'd2: begin r = ia * ib; lo = 8'(r % 256); hi = 8'(r / 256); end
            default: begin
                if (ib == 0) begin lo = 8'hFF; hi = a; dz = 1'b1; end
                else begin lo = 8'(ia / ib); hi = 8'(ia % ib); end
            end
        endcase
        sts = {3'b000, dz, cb, ({hi, lo} == 16'h0), op};
    endfunction

    task automatic send_byte(input logic [7:0] d, input string tag);
        int t;
        t        = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            tick(1);
            t++;
        end
        if (!in_ready) check({tag, " in_ready timeout"}, 32'(in_ready), 32'd1);
        else tick(1);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic recv_byte(input logic [7:0] exp, input int hold, input string tag);
        int t;
        logic [7:0] first;
        t = 0;
        while (!out_valid && t < 50) begin
            tick(1);
            t++;
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        first = out_data;
        for (int i = 0; i < hold; i++) begin
            tick(1);
            check({tag, " held data"}, 32'(out_data), 32'(first));
            check({tag, " held in_ready"}, 32'(in_ready), 32'd0);
        end
        check({tag, " data"}, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int hold, input string tag);
        logic [7:0] lo, hi, sts;
        int lat, exp_lat;
        model(op, a, b, lo, hi, sts);
        exp_lat = (op == 2'd3 && b != 8'd0) ? int'(DIV_CYC) + 2 : 2;
        send_byte({6'($urandom), op}, {tag, " op"});
        check({tag, " busy rise"}, 32'(busy), 32'd1);
        send_byte(a, {tag, " A"});
        send_byte(b, {tag, " B"});
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick(1);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (STS_EN) recv_byte(sts, 0, {tag, " sts"});
        recv_byte(lo, hold, {tag, " lo"});
        check({tag, " busy before hi"}, 32'(busy), 32'd1);
        recv_byte(hi, 0, {tag, " hi"});
        check({tag, " busy fall"}, 32'(busy), 32'd0);
        check({tag, " in_ready after"}, 32'(in_ready), 32'd1);
        if (op == 2'd3 && b == 8'd0) exp_div0 = 1'b1;
        check({tag, " div0"}, 32'(div0), 32'(exp_div0));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick(3);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset div0", 32'(div0), 32'd0);
        check("io_oeb", 32'(io_oeb), 32'h00003FF);
        rst_n = 1'b1;
        check("release in_ready", 32'(in_ready), 32'd0);
        tick(1);
        check("first edge in_ready", 32'(in_ready), 32'd1);

        run_cmd(2'd0, 8'hC8, 8'h64, 0, "add200+100");
        run_cmd(2'd1, 8'h05, 8'h0A, 0, "sub5-10");
        run_cmd(2'd2, 8'hFF, 8'hFF, 0, "mul255*255");
        run_cmd(2'd3, 8'h64, 8'h07, 0, "div100/7");
        run_cmd(2'd3, 8'h2A, 8'h00, 0, "div42/0");
        run_cmd(2'd0, 8'h01, 8'h02, 0, "add after div0");
        run_cmd(2'd0, 8'h10, 8'h20, 5, "hold lo");
        run_cmd(2'd1, 8'h80, 8'h80, 0, "back-to-back");

        // Reset mid-division
        send_byte(8'h03, "abort op");
        send_byte(8'h64, "abort A");
        send_byte(8'h07, "abort B");
        tick(4);
        rst_n = 1'b0;
        #1;
        check("abort in_ready", 32'(in_ready), 32'd0);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort out_data", 32'(out_data), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort div0", 32'(div0), 32'd0);
        exp_div0 = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("abort release in_ready", 32'(in_ready), 32'd1);
        run_cmd(2'd0, 8'h7F, 8'h81, 0, "add after abort");

        for (int i = 0; i < 24; i++) begin
            logic [1:0] op;
            logic [7:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            run_cmd(op, a, b, int'($urandom_range(0, 2)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
